aer_grant_responder: RTL and testbench

//  Receiver/arbiter end of the AER channel handshake. Per-channel up/down FSMs raise Req[i] and wait for Gnt[i].

---
 rtl/aer_grant_responder.sv | 214 +++++++++++++++++++++
 tb/tb_aer_grant_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_grant_responder.sv
// AER receiver-side responder: round-robin grant, timed Fs_sen/Fe_d handshake, one decoded event per handshake.
// Optional watchdog on GRANT/HOLD/RELEASE is built only when AER_RESP_TIMEOUT_EN is defined.
module aer_grant_responder #(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int FS_DLY = 2,
    parameter int FE_DLY = 3,
    parameter int TMO    = 31
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] Req,
    input  logic           go,
    input  logic [NCH-1:0] Ch_in,
    input  logic           Down_in,
    output logic [NCH-1:0] Gnt,
    output logic           Fs_sen,
    output logic           Fe_d,
    output logic           ev_valid,
    output logic [CHW-1:0] ev_ch,
    output logic           ev_down,
    output logic           busy,
    output logic           err_proto,
    output logic           err_tmo
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_SENSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_FEND  = 3'd4;
    localparam logic [2:0] S_REL   = 3'd5;

    if (CHW != $clog2(NCH) || NCH < 2 || NCH > 16 || FS_DLY < 1 || FS_DLY > 15 ||
        FE_DLY < 1 || FE_DLY > 15 || TMO < 1 || TMO > 255) begin : g_bad_cfg
        $error("aer_grant_responder: illegal parameter set");
    end

    logic [2:0]     state, state_n;
    logic [CHW-1:0] k_reg, k_n, rr_ptr, rr_n;
    logic [3:0]     cnt, cnt_n;
    logic [NCH-1:0] gnt_n;
    logic           fs_n, fe_n, evv_n, evd_n, perr_n, busy_n;
    logic [CHW-1:0] evc_n;

    // Round-robin search: first set request at or above rr_ptr, wrapping.
    logic           found;
    logic [CHW-1:0] pick;
    always_comb begin : rr_search
        int c;
        c     = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NCH; i++) begin
            c = (int'(rr_ptr) + i) % NCH;
            if (!found && Req[c]) begin
                found = 1'b1;
                pick  = CHW'(c);
            end
        end
    end

`ifdef AER_RESP_TIMEOUT_EN
    logic [7:0] wd;
    logic       terr_n;
    logic       watched;
    assign watched = (state == S_GRANT) || (state == S_HOLD) || (state == S_REL);
`endif

    always_comb begin
        state_n = state;
        k_n     = k_reg;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        gnt_n   = Gnt;
        fs_n    = Fs_sen;
        fe_n    = Fe_d;
        evv_n   = 1'b0;
        evc_n   = ev_ch;
        evd_n   = ev_down;
        perr_n  = 1'b0;
`ifdef AER_RESP_TIMEOUT_EN
        terr_n  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (found) begin
                    gnt_n   = NCH'(1) << pick;
                    k_n     = pick;
                    rr_n    = (pick == CHW'(NCH-1)) ? '0 : pick + 1'b1;
                    state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (go) begin
                    if (Ch_in == (NCH'(1) << k_reg)) begin
                        evd_n   = Down_in;
                        evc_n   = k_reg;
                        cnt_n   = 4'(FS_DLY-1);
                        state_n = S_SENSE;
                    end else begin
                        perr_n  = 1'b1;
                        gnt_n   = '0;
                        state_n = S_IDLE;
                    end
                end else if (!Req[k_reg]) begin
                    gnt_n   = '0;
                    state_n = S_IDLE;
                end
            end
            S_SENSE: begin
                // Sender gave up before acceptance: drop the event but still close out with Fe_d.
                if (!go) begin
                    perr_n  = 1'b1;
                    cnt_n   = 4'(FE_DLY-1);
                    state_n = S_FEND;
                end else if (cnt == 4'd0) begin
                    fs_n    = 1'b1;
                    evv_n   = 1'b1;
                    state_n = S_HOLD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (!go) begin
                    cnt_n   = 4'(FE_DLY-1);
                    state_n = S_FEND;
                end
            end
            S_FEND: begin
                if (cnt == 4'd0) begin
                    fe_n    = 1'b1;
                    gnt_n   = '0;
                    state_n = S_REL;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_REL: begin
                if (!Req[k_reg]) begin
                    fs_n    = 1'b0;
                    fe_n    = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                gnt_n   = '0;
                fs_n    = 1'b0;
                fe_n    = 1'b0;
                state_n = S_IDLE;
            end
        endcase
`ifdef AER_RESP_TIMEOUT_EN
        if (watched && state_n == state && wd == 8'(TMO-1)) begin
            terr_n  = 1'b1;
            gnt_n   = '0;
            fs_n    = 1'b0;
            fe_n    = 1'b0;
            state_n = S_IDLE;
        end
`endif
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            k_reg     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            Gnt       <= '0;
            Fs_sen    <= 1'b0;
            Fe_d      <= 1'b0;
            ev_valid  <= 1'b0;
            ev_ch     <= '0;
            ev_down   <= 1'b0;
            busy      <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            state     <= state_n;
            k_reg     <= k_n;
            rr_ptr    <= rr_n;
            cnt       <= cnt_n;
            Gnt       <= gnt_n;
            Fs_sen    <= fs_n;
            Fe_d      <= fe_n;
            ev_valid  <= evv_n;
            ev_ch     <= evc_n;
            ev_down   <= evd_n;
            busy      <= busy_n;
            err_proto <= perr_n;
        end
    end

`ifdef AER_RESP_TIMEOUT_EN
    // Watchdog restarts on every state change and saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd      <= '0;
            err_tmo <= 1'b0;
        end else begin
            err_tmo <= terr_n;
            if (watched && state_n == state)
                wd <= (wd == 8'hFF) ? wd : wd + 8'd1;
            else
                wd <= '0;
        end
    end
`else
    assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_aer_grant_responder.sv
// Randomized self-checking bench for aer_grant_responder; the bench plays the granted sender and
// predicts grant order and handshake timing from the protocol rules.
module tb_aer_grant_responder;
    localparam int NCH = 4, CHW = 2, FS_DLY = 2, FE_DLY = 3, TMO = 31;

    logic           clk = 1'b0, reset = 1'b1, go = 1'b0, down_in = 1'b0;
    logic [NCH-1:0] req = '0, ch_in = '0;
    logic [NCH-1:0] gnt;
    logic           fs_sen, fe_d, ev_valid, ev_down, busy, err_proto, err_tmo;
    logic [CHW-1:0] ev_ch;

    int ncmp = 0, nerr = 0, rr = 0, nev = 0, exp_ev = 0;

    aer_grant_responder #(.NCH(NCH), .CHW(CHW), .FS_DLY(FS_DLY), .FE_DLY(FE_DLY), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .Req(req), .go(go), .Ch_in(ch_in), .Down_in(down_in),
        .Gnt(gnt), .Fs_sen(fs_sen), .Fe_d(fe_d), .ev_valid(ev_valid), .ev_ch(ev_ch),
        .ev_down(ev_down), .busy(busy), .err_proto(err_proto), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (ev_valid === 1'b1) nev++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first requester at or after the pointer, circularly.
    function automatic int pick(input logic [NCH-1:0] r, input int p);
        for (int i = 0; i < NCH; i++)
            if (r[(p + i) % NCH]) return (p + i) % NCH;
        return -1;
    endfunction

    function automatic logic [NCH-1:0] oh(input int k);
        logic [NCH-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // One complete, well-behaved handshake for expected channel k.
    task automatic serve(input int k, input bit dn, input int gw, input int hw, input int rw, input bit rehold);
        logic [NCH-1:0] o;
        o = oh(k);
        step();
        ncmp++;
        if (gnt !== o || busy !== 1'b1) begin
            nerr++; $display("FAIL grant: gnt=%b busy=%b, want gnt=%b busy=1", gnt, busy, o);
        end
        rr = (k + 1) % NCH;
        repeat (gw) step();
        ncmp++;
        if (gnt !== o || fs_sen !== 1'b0) begin
            nerr++; $display("FAIL grant_wait: gnt=%b fs=%b, want gnt=%b fs=0", gnt, fs_sen, o);
        end
        go = 1'b1; ch_in = o; down_in = dn;
        for (int i = 0; i <= FS_DLY; i++) begin
            step();
            ncmp++;
            if (i < FS_DLY) begin
                if (fs_sen !== 1'b0 || ev_valid !== 1'b0) begin
                    nerr++; $display("FAIL fs_early(%0d): fs=%b ev=%b, want 0/0", i, fs_sen, ev_valid);
                end
            end else if (fs_sen !== 1'b1 || ev_valid !== 1'b1 || ev_ch !== CHW'(k) || ev_down !== dn) begin
                nerr++; $display("FAIL event: fs=%b ev=%b ch=%0d dn=%b, want 1/1/%0d/%b",
                                 fs_sen, ev_valid, ev_ch, ev_down, k, dn);
            end
        end
        exp_ev++;
        repeat (hw + 1) step();
        ncmp++;
        if (ev_valid !== 1'b0 || fs_sen !== 1'b1 || fe_d !== 1'b0 || gnt !== o) begin
            nerr++; $display("FAIL hold: ev=%b fs=%b fe=%b gnt=%b, want 0/1/0/%b", ev_valid, fs_sen, fe_d, gnt, o);
        end
        go = 1'b0; ch_in = '0;
        for (int i = 0; i <= FE_DLY; i++) begin
            step();
            ncmp++;
            if (i < FE_DLY) begin
                if (fe_d !== 1'b0 || gnt !== o) begin
                    nerr++; $display("FAIL fe_early(%0d): fe=%b gnt=%b, want 0/%b", i, fe_d, gnt, o);
                end
            end else if (fe_d !== 1'b1 || gnt !== '0 || fs_sen !== 1'b1) begin
                nerr++; $display("FAIL fe: fe=%b gnt=%b fs=%b, want 1/0/1", fe_d, gnt, fs_sen);
            end
        end
        repeat (rw) step();
        ncmp++;
        if (fe_d !== 1'b1 || fs_sen !== 1'b1 || busy !== 1'b1) begin
            nerr++; $display("FAIL release_wait: fe=%b fs=%b busy=%b, want 1/1/1", fe_d, fs_sen, busy);
        end
        req[k] = 1'b0;
        step();
        ncmp++;
        if (fs_sen !== 1'b0 || fe_d !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
            nerr++; $display("FAIL release: fs=%b fe=%b busy=%b gnt=%b, want all 0", fs_sen, fe_d, busy, gnt);
        end
        if (rehold) req[k] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '1;
        repeat (3) step();
        ncmp++;
        if ({gnt, fs_sen, fe_d, ev_valid, ev_ch, ev_down, busy, err_proto, err_tmo} !== '0) begin
            nerr++; $display("FAIL reset_outputs: gnt=%b fs=%b fe=%b ev=%b ch=%0d dn=%b busy=%b ep=%b et=%b, want 0",
                             gnt, fs_sen, fe_d, ev_valid, ev_ch, ev_down, busy, err_proto, err_tmo);
        end
        reset = 1'b0;
        step();
        ncmp++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            nerr++; $display("FAIL first_grant: gnt=%b busy=%b, want 0001/1", gnt, busy);
        end
        reset = 1'b1;
        step();
        ncmp++;
        if (gnt !== '0 || busy !== 1'b0) begin
            nerr++; $display("FAIL reset_mid: gnt=%b busy=%b, want 0/0", gnt, busy);
        end
        req = '0;
        step();
        reset = 1'b0;
        rr = 0;
    endtask

    task automatic test_single();
        req = 4'b0100;
        serve(pick(req, rr), 1'b1, 1, 1, 1, 1'b0);
    endtask

    task automatic test_round_robin();
        reset = 1'b1; step(); reset = 1'b0; rr = 0;
        req = '1;
        for (int n = 0; n < 5; n++)
            serve(pick(req, rr), n[0], $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
        req = '0;
    endtask

    task automatic test_req_drop();
        int k;
        req = oh($urandom_range(0, NCH-1));
        k = pick(req, rr);
        step();
        ncmp++;
        if (gnt !== oh(k)) begin
            nerr++; $display("FAIL drop_grant: gnt=%b, want %b", gnt, oh(k));
        end
        rr = (k + 1) % NCH;
        req = '0;
        step();
        ncmp++;
        if (gnt !== '0 || busy !== 1'b0 || err_proto !== 1'b0) begin
            nerr++; $display("FAIL drop_idle: gnt=%b busy=%b ep=%b, want 0/0/0", gnt, busy, err_proto);
        end
    endtask

    task automatic test_wrong_channel();
        int k;
        for (int v = 0; v < 2; v++) begin
            req = 4'b0010;
            k = pick(req, rr);
            step();
            ncmp++;
            if (gnt !== 4'b0010) begin
                nerr++; $display("FAIL wrong_grant: gnt=%b, want 0010", gnt);
            end
            rr = (k + 1) % NCH;
            go = 1'b1;
            ch_in = (v == 0) ? 4'b1000 : 4'b0110;
            req = '0;
            step();
            ncmp++;
            if (err_proto !== 1'b1 || gnt !== '0 || ev_valid !== 1'b0 || busy !== 1'b0) begin
                nerr++; $display("FAIL wrong_ch(%0d): ep=%b gnt=%b ev=%b busy=%b, want 1/0/0/0",
                                 v, err_proto, gnt, ev_valid, busy);
            end
            go = 1'b0; ch_in = '0;
            step();
            ncmp++;
            if (err_proto !== 1'b0 || busy !== 1'b0) begin
                nerr++; $display("FAIL wrong_pulse(%0d): ep=%b busy=%b, want 0/0", v, err_proto, busy);
            end
        end
    endtask

    task automatic test_go_lost();
        int k;
        req = 4'b0001;
        k = pick(req, rr);
        step();
        rr = (k + 1) % NCH;
        go = 1'b1; ch_in = oh(k); down_in = 1'b1;
        step();
        go = 1'b0; ch_in = '0;
        for (int i = 0; i <= FE_DLY; i++) begin
            step();
            ncmp++;
            if (i == 0) begin
                if (err_proto !== 1'b1 || ev_valid !== 1'b0 || fs_sen !== 1'b0) begin
                    nerr++; $display("FAIL golost_err: ep=%b ev=%b fs=%b, want 1/0/0", err_proto, ev_valid, fs_sen);
                end
            end else if (i < FE_DLY) begin
                if (err_proto !== 1'b0 || fe_d !== 1'b0 || ev_valid !== 1'b0) begin
                    nerr++; $display("FAIL golost_wait(%0d): ep=%b fe=%b ev=%b, want 0/0/0", i, err_proto, fe_d, ev_valid);
                end
            end else if (fe_d !== 1'b1 || gnt !== '0 || fs_sen !== 1'b0) begin
                nerr++; $display("FAIL golost_fe: fe=%b gnt=%b fs=%b, want 1/0/0", fe_d, gnt, fs_sen);
            end
        end
        req = '0;
        step();
        ncmp++;
        if (fe_d !== 1'b0 || busy !== 1'b0) begin
            nerr++; $display("FAIL golost_idle: fe=%b busy=%b, want 0/0", fe_d, busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            req = req | NCH'($urandom_range(0, (1 << NCH) - 1));
            if (req == '0) req = oh($urandom_range(0, NCH-1));
            serve(pick(req, rr), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        req = '0;
    endtask

    task automatic test_timeout();
        int k;
        bit bad;
        req = oh($urandom_range(0, NCH-1));
        k = pick(req, rr);
        step();
        rr = (k + 1) % NCH;
        bad = 1'b0;
`ifdef AER_RESP_TIMEOUT_EN
        repeat (TMO - 1) begin
            step();
            if (gnt !== oh(k) || err_tmo !== 1'b0) bad = 1'b1;
        end
        ncmp++;
        if (bad) begin
            nerr++; $display("FAIL tmo_early: gnt=%b et=%b, want %b/0 before limit", gnt, err_tmo, oh(k));
        end
        step();
        ncmp++;
        if (err_tmo !== 1'b1 || gnt !== '0 || busy !== 1'b0) begin
            nerr++; $display("FAIL tmo_fire: et=%b gnt=%b busy=%b, want 1/0/0", err_tmo, gnt, busy);
        end
        req = '0;
        step();
        ncmp++;
        if (err_tmo !== 1'b0 || gnt !== '0) begin
            nerr++; $display("FAIL tmo_pulse: et=%b gnt=%b, want 0/0", err_tmo, gnt);
        end
`else
        repeat (TMO + 10) begin
            step();
            if (gnt !== oh(k) || err_tmo !== 1'b0) bad = 1'b1;
        end
        ncmp++;
        if (bad) begin
            nerr++; $display("FAIL no_tmo: gnt=%b et=%b, want %b/0 held", gnt, err_tmo, oh(k));
        end
        req = '0;
        step();
        ncmp++;
        if (gnt !== '0 || busy !== 1'b0) begin
            nerr++; $display("FAIL no_tmo_drop: gnt=%b busy=%b, want 0/0", gnt, busy);
        end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_req_drop();
        test_wrong_channel();
        test_go_lost();
        test_random();
        test_timeout();
        step();
        ncmp++;
        if (nev !== exp_ev) begin
            nerr++; $display("FAIL event_count: saw %0d ev_valid pulses, want %0d", nev, exp_ev);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
